// File: rtl/hazard_unit.sv
// hazard_unit: RAW scoreboard, operand-forward select and branch/jump squash control; build with HAZARD_UNIT_FWD_EN for forwarding.
// Latency: stall/killF/killD/fwdA/fwdB are combinational from ID and the scoreboard; the scoreboard advances every clk edge.
// Backpressure: stall holds PC and IF/ID and drops a bubble into EX; a taken branch kills IF/ID and flushes for one cycle.
module hazard_unit (
    input  logic       clk,
    input  logic       reset,
    input  logic       id_valid,
    input  logic [3:0] id_opcode,
    input  logic [2:0] id_func,
    input  logic [2:0] id_rs1,
    input  logic [2:0] id_rs2,
    input  logic [2:0] id_rd,
    input  logic       id_rs1_used,
    input  logic       id_rs2_used,
    input  logic       id_regwr,
    input  logic       id_memrd,
    input  logic       ex_taken,
    output logic       stall,
    output logic       killF,
    output logic       killD,
    output logic [1:0] fwdA,
    output logic [1:0] fwdB
);
    localparam logic [3:0] OP_JMP  = 4'b0001;
    localparam logic [3:0] OP_NOOP = 4'b1111;

    typedef struct packed {
        logic       vld;
        logic       regwr;
        logic       memrd;
        logic [2:0] rd;
    } sb_entry_t;

    typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

    sb_entry_t ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
    state_t    state_q, state_d;
    logic      first_q, first_d;

    logic       out_gate, run_st, in_run, hazard;
    logic       a_ex, a_mem, b_ex, b_mem;
    logic [1:0] fwd_a, fwd_b;

    // The WB entry and id_func never create a hazard: the regfile writes before it reads.
    logic unused_inputs;
    assign unused_inputs = ^{id_func, wb_q};

    function automatic logic src_match(input sb_entry_t e, input logic [2:0] rs, input logic used);
        return e.vld && e.regwr && (e.rd != 3'd0) && used && (rs == e.rd);
    endfunction

    always_comb begin
        // Outputs stay quiet during reset and for the first cycle after release.
        out_gate = reset || first_q;
        run_st   = (state_q == RUN);
        in_run   = run_st && !out_gate;

        a_ex  = id_valid && src_match(ex_q,  id_rs1, id_rs1_used);
        a_mem = id_valid && src_match(mem_q, id_rs1, id_rs1_used);
        b_ex  = id_valid && src_match(ex_q,  id_rs2, id_rs2_used);
        b_mem = id_valid && src_match(mem_q, id_rs2, id_rs2_used);

`ifdef HAZARD_UNIT_FWD_EN
        hazard = ex_q.memrd && (a_ex || b_ex);
        // An EX-stage load is the newest producer but cannot forward yet; the stall covers it.
        fwd_a  = a_ex ? (ex_q.memrd ? 2'b00 : 2'b01) : (a_mem ? 2'b10 : 2'b00);
        fwd_b  = b_ex ? (ex_q.memrd ? 2'b00 : 2'b01) : (b_mem ? 2'b10 : 2'b00);
`else
        hazard = a_ex || a_mem || b_ex || b_mem;
        fwd_a  = 2'b00;
        fwd_b  = 2'b00;
`endif

        killD = in_run && ex_taken;
        stall = in_run && !ex_taken && hazard;
        killF = killD || (in_run && id_valid && (id_opcode == OP_JMP) && !stall);
        fwdA  = in_run ? fwd_a : 2'b00;
        fwdB  = in_run ? fwd_b : 2'b00;

        state_d = killD ? FLUSH : RUN;
        first_d = 1'b0;

        ex_d = '0;
        if (id_valid && run_st && !stall && !killD) begin
            ex_d.vld   = 1'b1;
            ex_d.regwr = id_regwr && (id_opcode != OP_NOOP);
            ex_d.memrd = id_memrd;
            ex_d.rd    = id_rd;
        end
        mem_d = ex_q;
        wb_d  = mem_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_q    <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
            state_q <= RUN;
            first_q <= 1'b1;
        end else begin
            ex_q    <= ex_d;
            mem_q   <= mem_d;
            wb_q    <= wb_d;
            state_q <= state_d;
            first_q <= first_d;
        end
    end
endmodule

// File: tb/tb_hazard_unit.sv
`timescale 1ns/1ps
module tb_hazard_unit;
    localparam logic [3:0] OP_JMP = 4'd1, OP_ADD = 4'd2, OP_LW = 4'd4, OP_AND = 4'd5, OP_NOOP = 4'd15;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid;
    logic [3:0] id_opcode;
    logic [2:0] id_func, id_rs1, id_rs2, id_rd;
    logic       id_rs1_used, id_rs2_used, id_regwr, id_memrd, ex_taken;
    logic       stall, killF, killD;
    logic [1:0] fwdA, fwdB;

    always #5 clk = ~clk;

    hazard_unit dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode), .id_func(id_func),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_rs1_used(id_rs1_used),
        .id_rs2_used(id_rs2_used), .id_regwr(id_regwr), .id_memrd(id_memrd), .ex_taken(ex_taken),
        .stall(stall), .killF(killF), .killD(killD), .fwdA(fwdA), .fwdB(fwdB)
    );

    int checks = 0;
    int errors = 0;
    logic [6:0] want;

    // Reference model: history of issued instructions, index 0 = newest (in EX).
    typedef struct { bit vld; bit regwr; bit memrd; bit [2:0] rd; } ins_t;
    ins_t hist[$];
    bit   m_flush, m_first;
    bit   e_stall, e_killF, e_killD;
    logic [6:0] e_out;

    function automatic logic [6:0] pk(input logic s, input logic kf, input logic kd,
                                      input logic [1:0] fa, input logic [1:0] fb);
        return {s, kf, kd, fa, fb};
    endfunction

    function automatic logic [6:0] outs();
        return {stall, killF, killD, fwdA, fwdB};
    endfunction

    function automatic void model_clear();
        ins_t z;
        z.vld = 0; z.regwr = 0; z.memrd = 0; z.rd = 0;
        hist.delete();
        for (int i = 0; i < 3; i++) hist.push_back(z);
        m_flush = 0;
        m_first = 1;
    endfunction

    function automatic int newest_producer(input bit [2:0] rs, input bit used);
        if (!id_valid || !used || rs == 3'd0) return -1;
        for (int i = 0; i < 2; i++)
            if (hist[i].vld && hist[i].regwr && hist[i].rd == rs) return i;
        return -1;
    endfunction

`ifdef HAZARD_UNIT_FWD_EN
    function automatic bit [1:0] fwd_sel(input int p);
        if (p == 0) return hist[0].memrd ? 2'd0 : 2'd1;
        if (p == 1) return 2'd2;
        return 2'd0;
    endfunction
`endif

    function automatic void model_eval();
        int pa, pb;
        bit run, haz;
        bit [1:0] fa, fb;
        pa  = newest_producer(id_rs1, id_rs1_used);
        pb  = newest_producer(id_rs2, id_rs2_used);
        run = !reset && !m_first && !m_flush;
`ifdef HAZARD_UNIT_FWD_EN
        haz = (pa == 0 || pb == 0) && hist[0].memrd;
        fa  = fwd_sel(pa);
        fb  = fwd_sel(pb);
`else
        haz = (pa >= 0) || (pb >= 0);
        fa  = 2'd0;
        fb  = 2'd0;
`endif
        e_killD = run && ex_taken;
        e_stall = run && !ex_taken && haz;
        e_killF = e_killD || (run && id_valid && id_opcode == OP_JMP && !e_stall);
        e_out   = {e_stall, e_killF, e_killD, run ? fa : 2'd0, run ? fb : 2'd0};
    endfunction

    function automatic void model_advance();
        ins_t n;
        if (reset) begin
            model_clear();
            return;
        end
        n.vld   = id_valid && !m_flush && !e_stall && !e_killD;
        n.regwr = n.vld && id_regwr && id_opcode != OP_NOOP;
        n.memrd = n.vld && id_memrd;
        n.rd    = id_rd;
        hist.push_front(n);
        void'(hist.pop_back());
        m_flush = e_killD;
        m_first = 0;
    endfunction

    task automatic tick();
        model_eval();
        @(posedge clk);
        model_advance();
        @(negedge clk);
    endtask

    task automatic set_id(input bit v, input logic [3:0] op, input logic [2:0] rd,
                          input logic [2:0] rs1, input bit u1, input logic [2:0] rs2, input bit u2,
                          input bit wr, input bit mr);
        id_valid = v; id_opcode = op; id_rd = rd; id_func = 3'($urandom_range(0, 7));
        id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
        id_regwr = wr; id_memrd = mr;
        #1;
    endtask

    task automatic flush_pipe();
        ex_taken = 0;
        set_id(0, OP_ADD, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) tick();
    endtask

    task automatic test_reset();
        reset = 1; ex_taken = 1;
        set_id(1, OP_JMP, 3, 1, 1, 2, 1, 1, 0);
        model_clear();
        want = 7'b0;
        if (outs() !== want) begin errors++; $display("FAIL reset_hold: got %b want %b", outs(), want); end
        checks++;
        @(posedge clk); @(negedge clk);
        reset = 0; #1;
        if (outs() !== want) begin errors++; $display("FAIL reset_first_cycle: got %b want %b", outs(), want); end
        checks++;
        tick();
        set_id(0, OP_ADD, 0, 0, 0, 0, 0, 0, 0);
        want = pk(0, 1, 1, 2'd0, 2'd0);
        if (outs() !== want) begin errors++; $display("FAIL reset_then_taken: got %b want %b", outs(), want); end
        checks++;
        tick();
        flush_pipe();
    endtask

    task automatic test_fwd_alu();
        flush_pipe();
        set_id(1, OP_ADD, 3, 1, 1, 2, 1, 1, 0);
        want = 7'b0;
        if (outs() !== want) begin errors++; $display("FAIL add_issue: got %b want %b", outs(), want); end
        checks++;
        tick();
        set_id(1, OP_ADD, 4, 3, 1, 2, 1, 1, 0);
`ifdef HAZARD_UNIT_FWD_EN
        want = pk(0, 0, 0, 2'd1, 2'd0);
        if (outs() !== want) begin errors++; $display("FAIL sub_fwd_ex: got %b want %b", outs(), want); end
        checks++;
`else
        for (int i = 0; i < 2; i++) begin
            want = pk(1, 0, 0, 2'd0, 2'd0);
            if (outs() !== want) begin errors++; $display("FAIL sub_stall%0d: got %b want %b", i, outs(), want); end
            checks++;
            tick();
        end
        want = 7'b0;
        if (outs() !== want) begin errors++; $display("FAIL sub_release: got %b want %b", outs(), want); end
        checks++;
`endif
        tick();
    endtask

    task automatic test_load_use();
        flush_pipe();
        set_id(1, OP_LW, 5, 1, 1, 0, 0, 1, 1);
        tick();
        set_id(1, OP_ADD, 6, 5, 1, 1, 1, 1, 0);
`ifdef HAZARD_UNIT_FWD_EN
        if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall: got %b want 1", stall); end
        checks++;
        tick();
        want = pk(0, 0, 0, 2'd2, 2'd0);
        if (outs() !== want) begin errors++; $display("FAIL lu_fwd_mem: got %b want %b", outs(), want); end
        checks++;
`else
        for (int i = 0; i < 2; i++) begin
            if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall%0d: got %b want 1", i, stall); end
            checks++;
            tick();
        end
        want = 7'b0;
        if (outs() !== want) begin errors++; $display("FAIL lu_release: got %b want %b", outs(), want); end
        checks++;
`endif
        tick();
        set_id(1, OP_ADD, 7, 5, 1, 5, 1, 1, 0);
        want = 7'b0;
        if (outs() !== want) begin errors++; $display("FAIL lu_wb_free: got %b want %b", outs(), want); end
        checks++;
        tick();
    endtask

    task automatic test_branch_kill();
        flush_pipe();
        set_id(1, OP_LW, 5, 1, 1, 0, 0, 1, 1);
        tick();
        ex_taken = 1;
        set_id(1, OP_ADD, 6, 5, 1, 1, 1, 1, 0);
        want = pk(0, 1, 1, 2'd0, 2'd0);
        if (outs() !== want) begin errors++; $display("FAIL br_kill: got %b want %b", outs(), want); end
        checks++;
        tick();
        set_id(1, OP_JMP, 0, 5, 1, 0, 0, 0, 0);
        want = 7'b0;
        if (outs() !== want) begin errors++; $display("FAIL br_flush_quiet: got %b want %b", outs(), want); end
        checks++;
        tick();
        ex_taken = 0;
        set_id(1, OP_JMP, 0, 6, 1, 6, 1, 0, 0);
        want = pk(0, 1, 0, 2'd0, 2'd0);
        if (outs() !== want) begin errors++; $display("FAIL br_back_to_run: got %b want %b", outs(), want); end
        checks++;
        tick();
    endtask

    task automatic test_jmp();
        flush_pipe();
        set_id(1, OP_JMP, 3, 1, 1, 0, 0, 0, 0);
        want = pk(0, 1, 0, 2'd0, 2'd0);
        if (outs() !== want) begin errors++; $display("FAIL jmp_killF: got %b want %b", outs(), want); end
        checks++;
        tick();
        set_id(1, OP_ADD, 4, 3, 1, 3, 1, 1, 0);
        want = 7'b0;
        if (outs() !== want) begin errors++; $display("FAIL jmp_no_write: got %b want %b", outs(), want); end
        checks++;
        tick();
        set_id(1, OP_LW, 5, 1, 1, 0, 0, 1, 1);
        tick();
        set_id(1, OP_JMP, 0, 5, 1, 0, 0, 0, 0);
        if ({stall, killF, killD} !== 3'b100) begin
            errors++; $display("FAIL jmp_stalled: got %b want 100", {stall, killF, killD});
        end
        checks++;
        tick();
    endtask

    task automatic test_r0_noop();
        flush_pipe();
        set_id(1, OP_ADD, 0, 1, 1, 2, 1, 1, 0);
        tick();
        set_id(1, OP_AND, 4, 0, 1, 0, 1, 1, 0);
        want = 7'b0;
        if (outs() !== want) begin errors++; $display("FAIL r0_no_hazard: got %b want %b", outs(), want); end
        checks++;
        tick();
        set_id(1, OP_NOOP, 3, 0, 0, 0, 0, 1, 0);
        tick();
        set_id(1, OP_ADD, 5, 3, 1, 3, 1, 1, 0);
        if (outs() !== want) begin errors++; $display("FAIL noop_no_write: got %b want %b", outs(), want); end
        checks++;
        tick();
    endtask

    task automatic test_reset_mid_stall();
        flush_pipe();
        set_id(1, OP_LW, 5, 1, 1, 0, 0, 1, 1);
        tick();
        set_id(1, OP_ADD, 6, 5, 1, 1, 1, 1, 0);
        if (stall !== 1'b1) begin errors++; $display("FAIL mid_stall_pre: got %b want 1", stall); end
        checks++;
        #2 reset = 1;
        #1;
        want = 7'b0;
        if (outs() !== want) begin errors++; $display("FAIL mid_stall_async: got %b want %b", outs(), want); end
        checks++;
        model_clear();
        @(posedge clk); @(negedge clk);
        reset = 0; #1;
        if (outs() !== want) begin errors++; $display("FAIL mid_stall_release: got %b want %b", outs(), want); end
        checks++;
        tick();
        set_id(1, OP_ADD, 7, 5, 1, 1, 1, 1, 0);
        if (outs() !== want) begin errors++; $display("FAIL post_reset_clear: got %b want %b", outs(), want); end
        checks++;
        tick();
    endtask

    task automatic test_reset_mid_flush();
        flush_pipe();
        ex_taken = 1;
        set_id(0, OP_ADD, 0, 0, 0, 0, 0, 0, 0);
        tick();
        ex_taken = 1;
        #1 reset = 1;
        #1;
        want = 7'b0;
        if (outs() !== want) begin errors++; $display("FAIL mid_flush_async: got %b want %b", outs(), want); end
        checks++;
        model_clear();
        @(posedge clk); @(negedge clk);
        reset = 0; #1;
        tick();
        want = pk(0, 1, 1, 2'd0, 2'd0);
        if (outs() !== want) begin errors++; $display("FAIL mid_flush_run: got %b want %b", outs(), want); end
        checks++;
        tick();
        flush_pipe();
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            ex_taken = ($urandom_range(0, 9) == 0);
            set_id($urandom_range(0, 9) < 8, 4'($urandom_range(0, 15)), 3'($urandom_range(0, 3)),
                   3'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   3'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0);
            model_eval();
            if (outs() !== e_out) begin
                errors++; $display("FAIL random cycle %0d: got %b want %b", n, outs(), e_out);
            end
            checks++;
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_fwd_alu();
        test_load_use();
        test_branch_kill();
        test_jmp();
        test_r0_noop();
        test_reset_mid_stall();
        test_reset_mid_flush();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
